// File: rtl/bram_sdp_fifo_ctrl_if.sv
// Stream and SDP block-RAM signal bundle for bram_sdp_fifo_ctrl.
// master is the controller side; slave is the surrounding logic (source, sink, RAM).
interface bram_sdp_fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 36
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  ram_wren;
    logic [ADDR_WIDTH-1:0] ram_wraddr;
    logic [DATA_WIDTH-1:0] ram_wrdata;
    logic                  ram_rden;
    logic                  ram_regce;
    logic [ADDR_WIDTH-1:0] ram_rdaddr;
    logic [DATA_WIDTH-1:0] ram_rddata;
    logic [ADDR_WIDTH+1:0] level;

    modport master (
        input  s_data, s_valid, m_ready, ram_rddata,
        output s_ready, m_data, m_valid, ram_wren, ram_wraddr, ram_wrdata,
               ram_rden, ram_regce, ram_rdaddr, level
    );

    modport slave (
        output s_data, s_valid, m_ready, ram_rddata,
        input  s_ready, m_data, m_valid, ram_wren, ram_wraddr, ram_wrdata,
               ram_rden, ram_regce, ram_rdaddr, level
    );
endinterface

// File: rtl/bram_sdp_fifo_ctrl.sv
// FIFO controller around an external SDP block RAM (write port B, read port A).
// Reads are prefetched into a 3-entry output buffer, giving first-word-fall-through output.
module bram_sdp_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned DOA_REG    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_sdp_fifo_ctrl_if.master bus
);
    localparam int unsigned LAT = (DOA_REG != 0) ? 2 : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_count;
    logic [LAT-1:0]        r_inflight;
    logic [DATA_WIDTH-1:0] r_obuf [3];
    logic [1:0]            r_buf_count;
    logic                  r_s_ready;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_cap;
    logic [1:0]            w_n_inflight;
    logic [1:0]            w_cap_idx;
    logic [1:0]            w_buf_count_next;
    logic [ADDR_WIDTH:0]   w_mem_count_next;

    assign w_n_inflight = 2'($countones(r_inflight));
    assign w_pop        = (r_buf_count != 2'd0) & bus.m_ready;
    assign w_cap        = r_inflight[LAT-1];
    assign w_wr         = bus.s_valid & r_s_ready;

    // Issue only while the output buffer has room for everything already in flight.
    assign w_rd = (r_mem_count != '0) &&
                  (({1'b0, r_buf_count} + {1'b0, w_n_inflight}) < (3'd3 + {2'b00, w_pop}));

    assign w_cap_idx        = r_buf_count - {1'b0, w_pop};
    assign w_buf_count_next = r_buf_count + {1'b0, w_cap} - {1'b0, w_pop};

    always_comb begin
        w_mem_count_next = r_mem_count;
        if (w_wr && !w_rd) begin
            w_mem_count_next = r_mem_count + CNT_ONE;
        end else if (!w_wr && w_rd) begin
            w_mem_count_next = r_mem_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_inflight  <= '0;
            r_buf_count <= '0;
            r_s_ready   <= 1'b0;
            r_obuf      <= '{default: '0};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_mem_count <= w_mem_count_next;
            r_s_ready   <= (w_mem_count_next < DEPTH);
            // Bit 0 is the newest issue; the word returns when its bit leaves the top.
            r_inflight  <= LAT'({r_inflight, w_rd});
            r_buf_count <= w_buf_count_next;
            if (w_pop) begin
                r_obuf[0] <= r_obuf[1];
                r_obuf[1] <= r_obuf[2];
            end
            if (w_cap) begin
                r_obuf[w_cap_idx] <= bus.ram_rddata;
            end
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.ram_wren   = w_wr;
    assign bus.ram_wraddr = r_wr_ptr;
    assign bus.ram_wrdata = bus.s_data;
    assign bus.ram_rden   = w_rd;
    assign bus.ram_rdaddr = r_rd_ptr;
    assign bus.ram_regce  = (DOA_REG != 0) ? r_inflight[0] : 1'b0;
    assign bus.m_valid    = (r_buf_count != 2'd0);
    assign bus.m_data     = r_obuf[0];
    assign bus.level      = (ADDR_WIDTH+2)'(r_mem_count) +
                            (ADDR_WIDTH+2)'(w_n_inflight) +
                            (ADDR_WIDTH+2)'(r_buf_count);
endmodule
